// File: rtl/axil_reg_bank_pkg.sv
// Shared constants, FSM state types and strobe helper for the AXI4-Lite register bank.
package axil_reg_bank_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned OFF_IRQ_STATUS = 0;
  localparam int unsigned OFF_IRQ_MASK   = 4;
  localparam int unsigned OFF_RW_BASE    = 8;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_RESP} rd_state_t;

  function automatic logic [31:0] byte_mask(input logic [3:0] strb);
    logic [31:0] m;
    m = '0;
    for (int unsigned b = 0; b < 4; b++) m[8*b +: 8] = {8{strb[b]}};
    return m;
  endfunction

endpackage

// File: rtl/axil_irq_ctrl.sv
// Edge-triggered interrupt capture with W1C status, mask and registered irq_out.
module axil_irq_ctrl #(
  parameter int unsigned NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic               status_we,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] wr_bits,
  input  logic [NUM_IRQ-1:0] wr_bmask,
  output logic [NUM_IRQ-1:0] status,
  output logic [NUM_IRQ-1:0] mask,
  output logic               irq_out
);

  logic [NUM_IRQ-1:0] irq_prev;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] status_n;
  logic [NUM_IRQ-1:0] mask_n;

  // A new edge is OR-ed in after the clear so that set wins over W1C
  always_comb begin
    rise     = irq_src & ~irq_prev;
    status_n = (status & ~(status_we ? wr_bits : '0)) | rise;
    mask_n   = mask_we ? ((mask & ~wr_bmask) | wr_bits) : mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_prev <= '0;
      status   <= '0;
      mask     <= '0;
      irq_out  <= 1'b0;
    end else begin
      irq_prev <= irq_src;
      status   <= status_n;
      mask     <= mask_n;
      irq_out  <= |(status & mask);
    end
  end

endmodule

// File: rtl/axil_reg_bank.sv
// AXI4-Lite slave with NUM_RW read-write, NUM_RO read-only registers and an interrupt block.
module axil_reg_bank
  import axil_reg_bank_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter int unsigned            DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = 32'h43C0_0000,
  parameter int unsigned            NUM_RW     = 4,
  parameter int unsigned            NUM_RO     = 2,
  parameter int unsigned            NUM_IRQ    = 8
) (
  input  logic                    sys_clk,
  input  logic                    sys_resetn,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [NUM_RW*32-1:0]    rw_reg_out,
  input  logic [NUM_RO*32-1:0]    ro_reg_in,
  input  logic [NUM_IRQ-1:0]      irq_src,
  output logic                    irq_out
);

  localparam int unsigned WORD_STATUS = OFF_IRQ_STATUS / 4;
  localparam int unsigned WORD_MASK   = OFF_IRQ_MASK / 4;
  localparam int unsigned WORD_RW     = OFF_RW_BASE / 4;
  localparam int unsigned WORD_RO     = WORD_RW + NUM_RW;
  localparam int unsigned WORD_END    = WORD_RO + NUM_RO;

  // Addresses below BASE_ADDR wrap to a huge word index and fall out of the map
  function automatic logic [ADDR_WIDTH-1:0] word_index(input logic [ADDR_WIDTH-1:0] a);
    return (a - BASE_ADDR) >> 2;
  endfunction

  wr_state_t wr_state, wr_state_n;
  rd_state_t rd_state, rd_state_n;

  logic [ADDR_WIDTH-1:0]   aw_addr_q, wr_addr_eff, wr_word, rd_word;
  logic [DATA_WIDTH-1:0]   w_data_q, wr_data_eff, wr_bits, bm, rd_val;
  logic [DATA_WIDTH/8-1:0] w_strb_q, wr_strb_eff;
  logic [1:0]              rd_resp;
  logic                    wr_commit, wr_mapped, status_we, mask_we;
  logic [NUM_RW*32-1:0]    rw_regs;
  logic [NUM_IRQ-1:0]      irq_status, irq_mask;

  always_comb begin
    wr_state_n    = wr_state;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    wr_commit     = 1'b0;
    wr_addr_eff   = aw_addr_q;
    wr_data_eff   = w_data_q;
    wr_strb_eff   = w_strb_q;
    case (wr_state)
      W_IDLE: begin
        s_axi_awready = 1'b1;
        s_axi_wready  = 1'b1;
        wr_addr_eff   = s_axi_awaddr;
        wr_data_eff   = s_axi_wdata;
        wr_strb_eff   = s_axi_wstrb;
        if (s_axi_awvalid && s_axi_wvalid) begin
          wr_commit  = 1'b1;
          wr_state_n = W_RESP;
        end else if (s_axi_awvalid) begin
          wr_state_n = W_ADDR;
        end else if (s_axi_wvalid) begin
          wr_state_n = W_DATA;
        end
      end
      W_ADDR: begin
        s_axi_wready = 1'b1;
        wr_data_eff  = s_axi_wdata;
        wr_strb_eff  = s_axi_wstrb;
        if (s_axi_wvalid) begin
          wr_commit  = 1'b1;
          wr_state_n = W_RESP;
        end
      end
      W_DATA: begin
        s_axi_awready = 1'b1;
        wr_addr_eff   = s_axi_awaddr;
        if (s_axi_awvalid) begin
          wr_commit  = 1'b1;
          wr_state_n = W_RESP;
        end
      end
      W_RESP: if (s_axi_bready) wr_state_n = W_IDLE;
      default: wr_state_n = W_IDLE;
    endcase
  end

  always_comb begin
    wr_word   = word_index(wr_addr_eff);
    wr_mapped = wr_word < ADDR_WIDTH'(WORD_RO);
    bm        = byte_mask(wr_strb_eff);
    wr_bits   = wr_data_eff & bm;
    status_we = wr_commit && (wr_word == ADDR_WIDTH'(WORD_STATUS));
    mask_we   = wr_commit && (wr_word == ADDR_WIDTH'(WORD_MASK));
  end

  assign s_axi_bvalid = (wr_state == W_RESP);

  always_ff @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      wr_state    <= W_IDLE;
      aw_addr_q   <= '0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      s_axi_bresp <= RESP_OKAY;
    end else begin
      wr_state <= wr_state_n;
      if (s_axi_awready && s_axi_awvalid) aw_addr_q <= s_axi_awaddr;
      if (s_axi_wready && s_axi_wvalid) begin
        w_data_q <= s_axi_wdata;
        w_strb_q <= s_axi_wstrb;
      end
      if (wr_commit) s_axi_bresp <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
    end
  end

  for (genvar i = 0; i < NUM_RW; i++) begin : g_rw
    always_ff @(posedge sys_clk or negedge sys_resetn) begin
      if (!sys_resetn) rw_regs[32*i +: 32] <= '0;
      else if (wr_commit && (wr_word == ADDR_WIDTH'(WORD_RW + i)))
        rw_regs[32*i +: 32] <= (rw_regs[32*i +: 32] & ~bm) | wr_bits;
    end
  end

  assign rw_reg_out = rw_regs;

  always_comb begin
    rd_word = word_index(s_axi_araddr);
    rd_val  = '0;
    rd_resp = RESP_SLVERR;
    if (rd_word == ADDR_WIDTH'(WORD_STATUS)) begin
      rd_val  = 32'(irq_status);
      rd_resp = RESP_OKAY;
    end else if (rd_word == ADDR_WIDTH'(WORD_MASK)) begin
      rd_val  = 32'(irq_mask);
      rd_resp = RESP_OKAY;
    end
    for (int unsigned i = 0; i < NUM_RW; i++)
      if (rd_word == ADDR_WIDTH'(WORD_RW + i)) begin
        rd_val  = rw_regs[32*i +: 32];
        rd_resp = RESP_OKAY;
      end
    for (int unsigned j = 0; j < NUM_RO; j++)
      if (rd_word == ADDR_WIDTH'(WORD_RO + j) && rd_word < ADDR_WIDTH'(WORD_END)) begin
        rd_val  = ro_reg_in[32*j +: 32];
        rd_resp = RESP_OKAY;
      end
  end

  always_comb begin
    rd_state_n    = rd_state;
    s_axi_arready = (rd_state == R_IDLE);
    case (rd_state)
      R_IDLE:  if (s_axi_arvalid) rd_state_n = R_RESP;
      R_RESP:  if (s_axi_rready) rd_state_n = R_IDLE;
      default: rd_state_n = R_IDLE;
    endcase
  end

  assign s_axi_rvalid = (rd_state == R_RESP);

  always_ff @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      rd_state    <= R_IDLE;
      s_axi_rdata <= '0;
      s_axi_rresp <= RESP_OKAY;
    end else begin
      rd_state <= rd_state_n;
      if (rd_state == R_IDLE && s_axi_arvalid) begin
        s_axi_rdata <= rd_val;
        s_axi_rresp <= rd_resp;
      end
    end
  end

  axil_irq_ctrl #(.NUM_IRQ(NUM_IRQ)) u_irq (
    .clk       (sys_clk),
    .rst_n     (sys_resetn),
    .irq_src   (irq_src),
    .status_we (status_we),
    .mask_we   (mask_we),
    .wr_bits   (wr_bits[NUM_IRQ-1:0]),
    .wr_bmask  (bm[NUM_IRQ-1:0]),
    .status    (irq_status),
    .mask      (irq_mask),
    .irq_out   (irq_out)
  );

endmodule

// File: tb/tb_axil_reg_bank.sv
// Directed self-checking bench for axil_reg_bank with default parameters.
module tb_axil_reg_bank;

  localparam logic [31:0] BASE = 32'h43C0_0000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  awaddr, wdata, araddr, rdata;
  logic [3:0]   wstrb;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [1:0]   bresp, rresp;
  logic [127:0] rw_reg_out;
  logic [63:0]  ro_reg_in;
  logic [7:0]   irq_src;
  logic         irq_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axil_reg_bank dut (
    .sys_clk       (clk),
    .sys_resetn    (rst_n),
    .s_axi_awaddr  (awaddr),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .rw_reg_out    (rw_reg_out),
    .ro_reg_in     (ro_reg_in),
    .irq_src       (irq_src),
    .irq_out       (irq_out)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int lead, output logic [1:0] resp);
    int n;
    @(posedge clk); #1;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1;
    if (lead == 0) wvalid = 1'b1;
    for (int k = 0; k < lead; k++) begin
      @(posedge clk); #1;
      awvalid = 1'b0;
      chk("split_awready", awready, 1'b0);
      chk("split_wready", wready, 1'b1);
    end
    wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 16) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bvalid", bvalid, 1'b1);
    resp = bresp;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    @(posedge clk); #1;
    araddr = a; arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 16) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rvalid", rvalid, 1'b1);
    d = rdata; resp = rresp;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  logic [31:0] d;
  logic [1:0]  r;

  initial begin
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    ro_reg_in = '0; irq_src = '0;
    #2 apply_reset();

    chk("rst_rw", rw_reg_out, '0);
    chk("rst_awready", awready, 1'b1);
    chk("rst_wready", wready, 1'b1);
    chk("rst_arready", arready, 1'b1);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_irq", irq_out, 1'b0);
    chk("rst_rdata", rdata, '0);

    do_write(BASE + 32'h08, 32'h1234_5678, 4'hF, 0, r);
    chk("w0_resp", r, 2'b00);
    chk("w0_reg", rw_reg_out[31:0], 32'h1234_5678);
    do_read(BASE + 32'h08, d, r);
    chk("r0_data", d, 32'h1234_5678);
    chk("r0_resp", r, 2'b00);

    apply_reset();
    chk("rst2_rw", rw_reg_out, '0);
    do_write(BASE + 32'h0C, 32'hAABB_CCDD, 4'h5, 3, r);
    chk("w1_resp", r, 2'b00);
    chk("w1_reg", rw_reg_out[63:32], 32'h00BB_00DD);

    ro_reg_in = {32'h0BAD_F00D, 32'h55AA_33CC};
    do_read(BASE + 32'h18, d, r);
    chk("ro0_data", d, 32'h55AA_33CC);
    chk("ro0_resp", r, 2'b00);
    do_read(BASE + 32'h1C, d, r);
    chk("ro1_data", d, 32'h0BAD_F00D);
    do_write(BASE + 32'h18, 32'hFFFF_FFFF, 4'hF, 0, r);
    chk("ro_wr_resp", r, 2'b10);
    do_read(BASE + 32'h18, d, r);
    chk("ro0_after", d, 32'h55AA_33CC);
    chk("ro_wr_rw", rw_reg_out, 128'h0000_0000_0000_0000_00BB_00DD_0000_0000);

    do_write(BASE + 32'h04, 32'hFFFF_FFFF, 4'hF, 0, r);
    do_read(BASE + 32'h04, d, r);
    chk("mask_wide", d, 32'h0000_00FF);
    do_write(BASE + 32'h04, 32'h0000_0001, 4'h1, 0, r);
    do_read(BASE + 32'h04, d, r);
    chk("mask_1", d, 32'h0000_0001);

    irq_src[0] = 1'b1;
    @(posedge clk); #1;
    chk("irq_lat1", irq_out, 1'b0);
    @(posedge clk); #1;
    chk("irq_lat2", irq_out, 1'b1);
    do_read(BASE, d, r);
    chk("status_set", d, 32'h0000_0001);

    do_write(BASE, 32'h0000_0001, 4'hF, 0, r);
    chk("clr_resp", r, 2'b00);
    chk("clr_irq", irq_out, 1'b0);
    do_read(BASE, d, r);
    chk("status_held", d, 32'h0000_0000);

    irq_src[0] = 1'b0;
    @(posedge clk); #1;
    irq_src[0] = 1'b1;
    @(posedge clk); #1;
    irq_src[0] = 1'b0;
    @(posedge clk); #1;
    awaddr = BASE; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    irq_src[0] = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    chk("coin_bvalid", bvalid, 1'b1);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    chk("coin_irq", irq_out, 1'b1);
    do_read(BASE, d, r);
    chk("coin_status", d, 32'h0000_0001);
    do_write(BASE + 32'h04, 32'h0, 4'hF, 0, r);
    chk("mask0_irq", irq_out, 1'b0);

    do_write(BASE + 32'h20, 32'h1234_5678, 4'hF, 0, r);
    chk("unm_wr_resp", r, 2'b10);
    do_read(BASE + 32'h20, d, r);
    chk("unm_rd_data", d, '0);
    chk("unm_rd_resp", r, 2'b10);
    do_read(32'h43BF_FFFC, d, r);
    chk("below_data", d, '0);
    chk("below_resp", r, 2'b10);
    chk("unm_rw", rw_reg_out, 128'h0000_0000_0000_0000_00BB_00DD_0000_0000);
    do_read(BASE + 32'h04, d, r);
    chk("unm_mask", d, 32'h0);

    @(posedge clk); #1;
    awaddr = BASE + 32'h08; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    chk("hold_commit", rw_reg_out[31:0], 32'hCAFE_F00D);
    for (int k = 0; k < 5; k++) begin
      chk("hold_bvalid", bvalid, 1'b1);
      chk("hold_bresp", bresp, 2'b00);
      chk("hold_awready", awready, 1'b0);
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("abort_bvalid", bvalid, 1'b0);
    chk("abort_rw", rw_reg_out, '0);
    @(posedge clk); #1 rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
